// File: rtl/bht_controller.sv
// bht_controller: 2-bit saturating branch history table, one access slot shared by predict and queued update.
// Latency: prediction result one cycle after acceptance; updates apply when they drain from the FIFO.
// Backpressure: pred_ready/upd_ready low during INIT and while the update FIFO is full. Option: BHT_GSHARE_EN.

module bht_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
endmodule

module bht_controller #(
  parameter int         IDX_W    = 4,
  parameter int         UQ_DEPTH = 2,
  parameter logic [1:0] INIT_CNT = 2'b11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_req,
  input  logic [IDX_W-1:0] pred_pc,
  output logic             pred_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             upd_req,
  input  logic [IDX_W-1:0] upd_pc,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             busy
);
  localparam int N = 2 ** IDX_W;

  typedef enum logic {S_INIT, S_RUN} state_t;
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } upd_entry_t;

  state_t           state_q, state_d;
  logic             run;
  logic [IDX_W-1:0] init_ptr;
  logic [1:0]       bht_mem [N];
  logic [IDX_W-1:0] pred_idx, upd_idx;
  logic             pred_acc, upd_acc, drain;
  logic             uq_full, uq_empty;
  upd_entry_t       uq_in, uq_head;
  logic [1:0]       cur_cnt, nxt_cnt;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && init_ptr == IDX_W'(N - 1)) state_d = S_RUN;
  end

  always_comb begin
    busy = (state_q == S_INIT);
    run  = (state_q == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst)       init_ptr <= '0;
    else if (busy) init_ptr <= init_ptr + IDX_W'(1);
  end

`ifdef BHT_GSHARE_EN
  logic [IDX_W-1:0] ghr;
  always_ff @(posedge clk) begin
    if (rst)          ghr <= '0;
    else if (upd_acc) ghr <= {ghr[IDX_W-2:0], upd_taken};
  end
  assign pred_idx = pred_pc ^ ghr;
  assign upd_idx  = upd_pc ^ ghr;
`else
  assign pred_idx = pred_pc;
  assign upd_idx  = upd_pc;
`endif

  // A full FIFO blocks predictions so the head is guaranteed a slot to drain.
  assign upd_ready  = run && !uq_full;
  assign pred_ready = run && !uq_full;
  assign pred_acc   = pred_req && pred_ready;
  assign upd_acc    = upd_req && upd_ready;
  assign drain      = run && !uq_empty && !pred_acc;

  assign uq_in = '{idx: upd_idx, taken: upd_taken};

  bht_fifo #(.W($bits(upd_entry_t)), .DEPTH(UQ_DEPTH)) u_uq (
    .clk      (clk),
    .rst      (rst),
    .push     (upd_acc),
    .push_dat (uq_in),
    .pop      (drain),
    .pop_dat  (uq_head),
    .full     (uq_full),
    .empty    (uq_empty)
  );

  always_comb begin
    cur_cnt = bht_mem[uq_head.idx];
    nxt_cnt = cur_cnt;
    if (uq_head.taken) begin
      if (cur_cnt != 2'b11) nxt_cnt = cur_cnt + 2'd1;
    end else begin
      if (cur_cnt != 2'b00) nxt_cnt = cur_cnt - 2'd1;
    end
  end

  // Entries are not reset directly; INIT rewrites every one after any rst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy)       bht_mem[init_ptr]    <= INIT_CNT;
      else if (drain) bht_mem[uq_head.idx] <= nxt_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
    end else begin
      pred_valid <= pred_acc;
      if (pred_acc) pred_taken <= bht_mem[pred_idx][1];
    end
  end
endmodule

// File: tb/tb_bht_controller.sv
// Directed self-checking bench for bht_controller; each scenario task checks its own expected values.
module tb_bht_controller;
  logic       clk = 1'b0;
  logic       rst;
  logic       pred_req;
  logic [3:0] pred_pc;
  logic       pred_ready, pred_valid, pred_taken;
  logic       upd_req;
  logic [3:0] upd_pc;
  logic       upd_taken;
  logic       upd_ready, busy;

  int n_chk  = 0;
  int n_fail = 0;

  bht_controller dut (
    .clk        (clk),
    .rst        (rst),
    .pred_req   (pred_req),
    .pred_pc    (pred_pc),
    .pred_ready (pred_ready),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .upd_req    (upd_req),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_ready  (upd_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Called on the first cycle after rst drops: expects 16 INIT cycles then RUN.
  task automatic check_init(input string tag);
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if ({busy, pred_ready, upd_ready} !== 3'b100) begin
        n_fail++;
        $display("FAIL %s_init_cycle%0d busy/pred_ready/upd_ready got %b want 100", tag, i, {busy, pred_ready, upd_ready});
      end
      tick();
    end
    n_chk++;
    if ({busy, pred_ready, upd_ready} !== 3'b011) begin
      n_fail++;
      $display("FAIL %s_run_entry busy/pred_ready/upd_ready got %b want 011", tag, {busy, pred_ready, upd_ready});
    end
  endtask

  task automatic do_pred(input logic [3:0] pc, input logic exp, input string tag);
    n_chk++;
    if (pred_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_pred_ready got %b want 1", tag, pred_ready);
    end
    pred_req = 1'b1;
    pred_pc  = pc;
    tick();
    pred_req = 1'b0;
    n_chk++;
    if ({pred_valid, pred_taken} !== {1'b1, exp}) begin
      n_fail++;
      $display("FAIL %s valid/taken got %b%b want 1%b", tag, pred_valid, pred_taken, exp);
    end
    tick();
    n_chk++;
    if ({pred_valid, pred_taken} !== {1'b0, exp}) begin
      n_fail++;
      $display("FAIL %s_hold valid/taken got %b%b want 0%b", tag, pred_valid, pred_taken, exp);
    end
  endtask

  task automatic do_upd(input logic [3:0] pc, input logic tk, input string tag);
    int w = 0;
    while (upd_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    n_chk++;
    if (upd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_upd_ready timeout got %b want 1", tag, upd_ready);
    end
    upd_req   = 1'b1;
    upd_pc    = pc;
    upd_taken = tk;
    tick();
    upd_req = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pred_req = 1'b1;
    pred_pc = 4'd0;
    upd_req = 1'b0;
    upd_pc = 4'd0;
    upd_taken = 1'b0;
    idle(2);
    n_chk++;
    if ({busy, pred_ready, upd_ready, pred_valid, pred_taken} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_state busy/prdy/urdy/pvld/ptkn got %b want 10000",
               {busy, pred_ready, upd_ready, pred_valid, pred_taken});
    end
    pred_req = 1'b0;
    rst = 1'b0;
    check_init("reset");
    do_pred(4'd3, 1'b1, "pred_pc3_after_init");
  endtask

  task automatic test_counter_down_up();
    do_upd(4'd5, 1'b0, "pc5_nt1");
    do_upd(4'd5, 1'b0, "pc5_nt2");
    idle(3);
    do_pred(4'd5, 1'b0, "pc5_cnt01");
    do_upd(4'd5, 1'b0, "pc5_nt3");
    idle(3);
    do_pred(4'd5, 1'b0, "pc5_cnt00");
    do_upd(4'd5, 1'b1, "pc5_t1");
    idle(3);
    do_pred(4'd5, 1'b0, "pc5_cnt01_up");
    do_upd(4'd5, 1'b1, "pc5_t2");
    idle(3);
    do_pred(4'd5, 1'b1, "pc5_cnt10");
  endtask

  task automatic test_saturate_high();
    do_upd(4'd7, 1'b1, "pc7_t1");
    do_upd(4'd7, 1'b1, "pc7_t2");
    do_upd(4'd7, 1'b1, "pc7_t3");
    idle(3);
    do_pred(4'd7, 1'b1, "pc7_cnt11");
    do_upd(4'd7, 1'b0, "pc7_nt1");
    idle(3);
    do_pred(4'd7, 1'b1, "pc7_cnt10");
    do_upd(4'd7, 1'b0, "pc7_nt2");
    idle(3);
    do_pred(4'd7, 1'b0, "pc7_cnt01");
  endtask

  task automatic test_back_to_back();
    pred_req = 1'b1;
    pred_pc = 4'd9;
    upd_req = 1'b1;
    upd_pc = 4'd10;
    upd_taken = 1'b0;
    tick();
    n_chk++;
    if ({pred_valid, pred_taken, pred_ready, upd_ready} !== 4'b1111) begin
      n_fail++;
      $display("FAIL b2b_first vld/tkn/prdy/urdy got %b want 1111", {pred_valid, pred_taken, pred_ready, upd_ready});
    end
    tick();
    upd_req = 1'b0;
    n_chk++;
    if ({pred_valid, pred_taken, pred_ready, upd_ready} !== 4'b1100) begin
      n_fail++;
      $display("FAIL b2b_full vld/tkn/prdy/urdy got %b want 1100", {pred_valid, pred_taken, pred_ready, upd_ready});
    end
    tick();
    n_chk++;
    if ({pred_valid, pred_taken, pred_ready, upd_ready} !== 4'b0111) begin
      n_fail++;
      $display("FAIL b2b_drain vld/tkn/prdy/urdy got %b want 0111", {pred_valid, pred_taken, pred_ready, upd_ready});
    end
    tick();
    pred_req = 1'b0;
    n_chk++;
    if ({pred_valid, pred_taken} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_resume vld/tkn got %b want 11", {pred_valid, pred_taken});
    end
    idle(3);
    do_pred(4'd10, 1'b0, "b2b_pc10_both_applied");
  endtask

  task automatic test_enq_and_drain();
    do_upd(4'd11, 1'b0, "pc11_nt1");
    upd_req = 1'b1;
    upd_pc = 4'd11;
    upd_taken = 1'b0;
    tick();
    upd_req = 1'b0;
    n_chk++;
    if ({pred_ready, upd_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL enq_drain_ready prdy/urdy got %b want 11", {pred_ready, upd_ready});
    end
    idle(3);
    do_pred(4'd11, 1'b0, "enq_drain_pc11_cnt01");
    do_upd(4'd11, 1'b1, "pc11_t1");
    do_upd(4'd11, 1'b0, "pc11_nt3");
    idle(3);
    do_pred(4'd11, 1'b0, "enq_drain_pc11_order");
  endtask

  task automatic test_reset_mid_run();
    pred_req = 1'b1;
    pred_pc = 4'd0;
    upd_req = 1'b1;
    upd_pc = 4'd2;
    upd_taken = 1'b0;
    idle(2);
    upd_req = 1'b0;
    rst = 1'b1;
    tick();
    pred_req = 1'b0;
    n_chk++;
    if ({busy, pred_ready, upd_ready, pred_valid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL midrst_state busy/prdy/urdy/pvld got %b want 1000", {busy, pred_ready, upd_ready, pred_valid});
    end
    rst = 1'b0;
    check_init("midrst");
    idle(3);
    do_pred(4'd2, 1'b1, "midrst_pc2_dropped");
  endtask

`ifdef BHT_GSHARE_EN
  task automatic test_gshare();
    apply_reset();
    check_init("gshare");
    do_upd(4'd0, 1'b1, "gs_pc0_t");
    do_upd(4'd1, 1'b0, "gs_pc1_nt");
    idle(3);
    do_pred(4'd1, 1'b1, "gs_pred_pc1_idx3");
    do_pred(4'd2, 1'b1, "gs_pred_pc2_idx0");
  endtask
`endif

  initial begin
    test_reset();
    test_counter_down_up();
    test_saturate_high();
    test_back_to_back();
    test_enq_and_drain();
    test_reset_mid_run();
`ifdef BHT_GSHARE_EN
    test_gshare();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
